fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_ctrl_if.sv | 9 +
 rtl/fetch_ctrl_sat_wrap_counter.sv | 19 +
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-path definitions: the pc_sel encoding, the fetch FSM states, the reset PC
// and the control-flow opcodes that produce redirects.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_JAL = 2'b01,
        SEL_BR  = 2'b10,
        SEL_ILL = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_REDIR = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ready handshake between the fetch unit (master) and memory (slave).
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/fetch_ctrl_sat_wrap_counter.sv
// Event counter that wraps modulo 2^WIDTH.
module sat_wrap_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;

    assign count_d = inc_i ? count_q + WIDTH'(1) : count_q;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: sequential fetch, memory wait states, stall hold and
// redirects with decode flush, including redirects that arrive while a fetch is outstanding.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_ctrl_if.master       imem,
    input  logic [1:0]         pc_sel_i,
    input  logic               ex_valid_i,
    input  logic [31:0]        jal_target_i,
    input  logic [31:0]        br_target_i,
    input  logic               stall_i,
    output logic [31:0]        fd_pc_o,
    output logic               fd_valid_o,
    output logic               flush_d_o,
    output logic [CNT_W-1:0]   redirect_cnt_o,
    output logic               sel_err_o
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pend_pc_q, pend_pc_d, fd_pc_q, fd_pc_d;
    logic         pend_q, pend_d, fd_valid_q, fd_valid_d;
    logic         req_q, req_d, sel_err_q, sel_err_d;
    pc_sel_e      sel;
    logic         redirect, xfer;
    logic [31:0]  target;

    assign sel      = pc_sel_e'(pc_sel_i);
    assign redirect = ex_valid_i && (sel == SEL_JAL || sel == SEL_BR);
    assign target   = (sel == SEL_JAL) ? jal_target_i : br_target_i;
    assign xfer     = req_q && imem.imem_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = pend_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        sel_err_d  = sel_err_q | (ex_valid_i && sel == SEL_ILL);
        case (state_q)
            ST_BOOT, ST_REDIR: begin
                fd_valid_d = 1'b0;
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_REDIR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d       = target;
                    fd_valid_d = 1'b0;
                    state_d    = ST_REDIR;
                end else if (!stall_i) begin
                    if (xfer) begin
                        fd_pc_d    = pc_q;
                        fd_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        fd_valid_d = 1'b0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The outstanding fetch must finish before the redirect target can be issued.
                if (redirect) begin
                    pend_pc_d = target;
                    pend_d    = 1'b1;
                end
                if (xfer) begin
                    if (pend_d) begin
                        pc_d    = pend_pc_d;
                        pend_d  = 1'b0;
                        state_d = ST_REDIR;
                    end else if (!stall_i) begin
                        fd_pc_d    = pc_q;
                        fd_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = ST_RUN;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
        req_d = (state_d == ST_RUN) || (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            pend_q     <= 1'b0;
            fd_pc_q    <= RESET_PC;
            fd_valid_q <= 1'b0;
            req_q      <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
            req_q      <= req_d;
            sel_err_q  <= sel_err_d;
        end
    end

    sat_wrap_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (redirect),
        .count_o (redirect_cnt_o)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign fd_pc_o        = fd_pc_q;
    assign fd_valid_o     = fd_valid_q;
    assign sel_err_o      = sel_err_q;
    // Flush is the only combinational output; it must read 0 while reset is held.
    assign flush_d_o      = redirect && rst_n;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a flag-based fetch model.
module tb_fetch_ctrl;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam int          VW     = 67 + CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       pc_sel = '0;
    logic             ex_valid = 1'b0, stall = 1'b0;
    logic [31:0]      jal_target = '0, br_target = '0;
    logic [31:0]      fd_pc;
    logic             fd_valid, flush_d, sel_err;
    logic [CNT_W-1:0] redirect_cnt;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .pc_sel_i       (pc_sel),
        .ex_valid_i     (ex_valid),
        .jal_target_i   (jal_target),
        .br_target_i    (br_target),
        .stall_i        (stall),
        .fd_pc_o        (fd_pc),
        .fd_valid_o     (fd_valid),
        .flush_d_o      (flush_d),
        .redirect_cnt_o (redirect_cnt),
        .sel_err_o      (sel_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bubble = a cycle with no fetch request (boot or post-redirect).
    bit          m_bub, m_wait, m_pend, m_err, m_fdv;
    logic [31:0] m_pc, m_ppc, m_fdpc;
    int          m_cnt;
    logic        exp_flush, flush_seen;

    task automatic model_reset();
        m_bub = 1; m_wait = 0; m_pend = 0; m_err = 0; m_fdv = 0;
        m_pc = RST_PC; m_ppc = RST_PC; m_fdpc = RST_PC; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit          redir;
        logic [31:0] tgt;
        redir = ex_valid && (pc_sel == 2'd1 || pc_sel == 2'd2);
        tgt   = (pc_sel == 2'd1) ? jal_target : br_target;
        if (ex_valid && pc_sel == 2'd3) m_err = 1;
        if (redir) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (m_bub) begin
            m_fdv = 0;
            if (redir) m_pc = tgt;
            else       m_bub = 0;
        end else if (!m_wait) begin
            if (redir) begin
                m_pc = tgt; m_fdv = 0; m_bub = 1;
            end else if (!stall) begin
                if (bus.imem_ready) begin
                    m_fdpc = m_pc; m_fdv = 1; m_pc = m_pc + 32'd4;
                end else begin
                    m_fdv = 0; m_wait = 1;
                end
            end
        end else begin
            if (redir) begin m_pend = 1; m_ppc = tgt; end
            if (bus.imem_ready) begin
                if (m_pend) begin
                    m_pc = m_ppc; m_pend = 0; m_bub = 1; m_wait = 0;
                end else if (!stall) begin
                    m_fdpc = m_pc; m_fdv = 1; m_pc = m_pc + 32'd4; m_wait = 0;
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] obs();
        return {bus.imem_req, bus.imem_addr, fd_pc, fd_valid, redirect_cnt, sel_err};
    endfunction

    function automatic logic [VW-1:0] expv();
        return {!m_bub, m_pc, m_fdpc, m_fdv, CNT_W'(m_cnt), m_err};
    endfunction

    function automatic logic [VW-1:0] reset_vec();
        return {1'b0, RST_PC, RST_PC, 1'b0, {CNT_W{1'b0}}, 1'b0};
    endfunction

    task automatic step(input logic ex, input logic [1:0] sel, input logic [31:0] jt,
                        input logic [31:0] bt, input logic st, input logic rdy);
        ex_valid = ex; pc_sel = sel; jal_target = jt; br_target = bt;
        stall = st; bus.imem_ready = rdy;
        exp_flush = ex && (sel == 2'd1 || sel == 2'd2);
        #2 flush_seen = flush_d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== reset_vec()) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs(), reset_vec());
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_boot_seq();
        for (int i = 0; i < 3; i++) begin
            step(0, 2'd0, '0, '0, 0, 1);
            total++;
            if (bus.imem_addr !== RST_PC + 32'(4 * i) || bus.imem_req !== 1'b1) begin
                bad++; $display("FAIL boot_addr%0d: got req=%b addr=%h want req=1 addr=%h",
                                i, bus.imem_req, bus.imem_addr, RST_PC + 32'(4 * i));
            end
            total++;
            if (obs() !== expv()) begin
                bad++; $display("FAIL boot_model%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_branch();
        step(0, 2'd0, '0, '0, 0, 1);
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== 32'h4000_0010) begin
            bad++; $display("FAIL branch_pre: got %h want 40000010", bus.imem_addr);
        end
        step(1, 2'd2, 32'h0, 32'h4000_0100, 0, 1);
        total++;
        if (flush_seen !== 1'b1) begin
            bad++; $display("FAIL branch_flush: got %b want 1", flush_seen);
        end
        total++;
        if (bus.imem_req !== 1'b0 || redirect_cnt !== CNT_W'(1)) begin
            bad++; $display("FAIL branch_bubble: got req=%b cnt=%0d want req=0 cnt=1", bus.imem_req, redirect_cnt);
        end
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== 32'h4000_0100 || bus.imem_req !== 1'b1 || obs() !== expv()) begin
            bad++; $display("FAIL branch_target: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_wait_jal();
        logic [31:0] want [6] = '{32'h4000_0020, 32'h4000_0020, 32'h4000_0020,
                                  32'h4000_0020, 32'h4000_0200, 32'h4000_0200};
        logic        wreq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1, 2'd1, 32'h4000_0020, '0, 0, 1);
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== want[0] || obs() !== expv()) begin
            bad++; $display("FAIL wait_start: got %h want %h", obs(), expv());
        end
        for (int i = 1; i < 6; i++) begin
            if (i == 2) step(1, 2'd1, 32'h4000_0200, '0, 0, 0);
            else        step(0, 2'd0, '0, '0, 0, (i >= 4));
            total++;
            if (bus.imem_addr !== want[i] || bus.imem_req !== wreq[i] || fd_valid !== 1'b0) begin
                bad++; $display("FAIL wait_seq%0d: got req=%b addr=%h fdv=%b want req=%b addr=%h fdv=0",
                                i, bus.imem_req, bus.imem_addr, fd_valid, wreq[i], want[i]);
            end
            total++;
            if (obs() !== expv() || flush_seen !== exp_flush) begin
                bad++; $display("FAIL wait_model%0d: got %h/%b want %h/%b", i, obs(), flush_seen, expv(), exp_flush);
            end
        end
    endtask

    task automatic test_stall_redirect();
        step(1, 2'd2, '0, 32'h4000_0300, 1, 1);
        total++;
        if (flush_seen !== 1'b1 || bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL stall_redir: got flush=%b req=%b want flush=1 req=0", flush_seen, bus.imem_req);
        end
        step(0, 2'd0, '0, '0, 1, 1);
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== 32'h4000_0304 || fd_pc !== 32'h4000_0300 || obs() !== expv()) begin
            bad++; $display("FAIL stall_resume: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_sel_err();
        logic [CNT_W-1:0] cnt0;
        logic [31:0]      a0;
        cnt0 = redirect_cnt; a0 = bus.imem_addr;
        step(1, 2'd3, 32'h1111_0000, 32'h2222_0000, 0, 1);
        total++;
        if (sel_err !== 1'b1 || redirect_cnt !== cnt0 || bus.imem_addr !== a0 + 32'd4 || flush_seen !== 1'b0) begin
            bad++; $display("FAIL sel_err: got err=%b cnt=%0d addr=%h flush=%b want err=1 cnt=%0d addr=%h flush=0",
                            sel_err, redirect_cnt, bus.imem_addr, flush_seen, cnt0, a0 + 32'd4);
        end
        step(0, 2'd3, '0, '0, 0, 1);
        total++;
        if (sel_err !== 1'b1 || obs() !== expv()) begin
            bad++; $display("FAIL sel_err_sticky: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_pc_wrap();
        step(1, 2'd1, 32'hFFFF_FFFC, '0, 0, 1);
        step(0, 2'd0, '0, '0, 0, 1);
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== 32'h0 || fd_pc !== 32'hFFFF_FFFC || fd_valid !== 1'b1) begin
            bad++; $display("FAIL pc_wrap: got addr=%h fd_pc=%h fdv=%b want addr=0 fd_pc=fffffffc fdv=1",
                            bus.imem_addr, fd_pc, fd_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        step(0, 2'd0, '0, '0, 0, 0);
        total++;
        if (bus.imem_req !== 1'b1 || obs() !== expv()) begin
            bad++; $display("FAIL rst_pre_wait: got %h want %h", obs(), expv());
        end
        ex_valid = 1'b1; pc_sel = 2'd1; jal_target = 32'h0000_0123; bus.imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== reset_vec() || flush_d !== 1'b0) begin
            bad++; $display("FAIL rst_async: got %h flush=%b want %h flush=0", obs(), flush_d, reset_vec());
        end
        ex_valid = 1'b0; pc_sel = 2'd0; bus.imem_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        total++;
        if (obs() !== reset_vec()) begin
            bad++; $display("FAIL rst_late_ready: got %h want %h", obs(), reset_vec());
        end
        step(0, 2'd0, '0, '0, 0, 1);
        total++;
        if (bus.imem_addr !== RST_PC || bus.imem_req !== 1'b1 || fd_valid !== 1'b0) begin
            bad++; $display("FAIL rst_restart: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
            total++;
            if (flush_seen !== exp_flush || obs() !== expv()) begin
                bad++; $display("FAIL random%0d: got %h flush=%b want %h flush=%b",
                                i, obs(), flush_seen, expv(), exp_flush);
            end
        end
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        model_reset();
        test_reset();
        test_boot_seq();
        test_branch();
        test_wait_jal();
        test_stall_redirect();
        test_sel_err();
        test_pc_wrap();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
